// File: rtl/stencil_pkg.sv
// stencil_pkg: shared types and helpers for the streaming stencil filter
package stencil_pkg;
  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DRAIN} state_e;
  typedef enum logic [1:0] {BRD_PASS, BRD_ZERO, BRD_MAX, BRD_RAW} border_e;
  function automatic int acc_w(int pix_w, int coef_w, int k);
    return pix_w + coef_w + $clog2(k * k) + 1;
  endfunction
  function automatic int default_coef(int k, int idx);
    return idx == k * k / 2 ? k * k - 1 : -1;
  endfunction
endpackage

// File: rtl/stencil_line_buffer.sv
// stencil_line_buffer: one-line delay RAM with registered read; LAG writes one slot behind to absorb the hop register
module stencil_line_buffer
  import stencil_pkg::*;
#(
  parameter int DEPTH = 128,
  parameter int WIDTH = 8,
  parameter bit LAG = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] addr, waddr;
  assign waddr = !LAG ? addr : addr == '0 ? AW'(DEPTH - 1) : addr - AW'(1);
  always_ff @(posedge clk) begin
    if (rst) addr <= '0;
    else if (en) addr <= addr == AW'(DEPTH - 1) ? '0 : addr + AW'(1);
  end
  always_ff @(posedge clk) begin
    if (en) begin
      dout <= mem[addr];
      mem[waddr] <= din;
    end
  end
endmodule

// File: rtl/stencil_filter_stream.sv
// stencil_filter_stream: streaming KxK convolution with clamp, shift and border policy
module stencil_filter_stream
  import stencil_pkg::*;
#(
  parameter int PIX_W = 8,
  parameter int COEF_W = 8,
  parameter int FRAME_W = 128,
  parameter int FRAME_H = 128,
  parameter int KERNEL_SIZE = 3
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       s_valid,
  output logic                                       s_ready,
  input  logic [PIX_W-1:0]                           s_data,
  output logic                                       m_valid,
  input  logic                                       m_ready,
  output logic [PIX_W-1:0]                           m_data,
  output logic                                       m_sof,
  output logic                                       m_last,
  input  logic                                       cfg_we,
  input  logic [$clog2(KERNEL_SIZE*KERNEL_SIZE)-1:0] cfg_idx,
  input  logic [COEF_W-1:0]                          cfg_coef,
  input  logic [4:0]                                 cfg_shift,
  input  logic [1:0]                                 cfg_border,
  output logic                                       cfg_err,
  output logic                                       busy
);
  localparam int K = KERNEL_SIZE, R = K / 2, KK = K * K;
  localparam int AW = acc_w(PIX_W, COEF_W, K);
  localparam int NPIX = FRAME_W * FRAME_H, OFF = R * FRAME_W + R, NTOT = NPIX + OFF;
  localparam int CW = $clog2(NTOT + 1), XW = $clog2(FRAME_W), YW = $clog2(FRAME_H);
  state_e state, state_n;
  border_e border;
  logic [4:0] shift;
  logic signed [COEF_W-1:0] coef [KK];
  logic [CW-1:0] in_cnt;
  logic [XW-1:0] out_col;
  logic [YW-1:0] out_row;
  logic adv, entry, v1, cfg_ok, brd, eol;
  logic [PIX_W-1:0] pix_in, pix_d, calc, out_pix;
  logic [PIX_W-1:0] rd [K-1];
  logic [PIX_W-1:0] win [K-1][K];
  logic [PIX_W-1:0] w [K][K];
  logic signed [AW-1:0] acc, sh;
  always_comb begin
    adv = !m_valid || m_ready;
    s_ready = adv && (state == IDLE || state == RUN);
    entry = state == FLUSH ? adv : s_valid && s_ready;
    pix_in = state == FLUSH ? '0 : s_data;
    busy = state != IDLE;
    cfg_ok = state == IDLE && !entry && 32'(cfg_idx) < KK;
    state_n = state;
    case (state)
      IDLE:    state_n = entry ? RUN : IDLE;
      RUN:     state_n = entry && in_cnt == CW'(NPIX - 1) ? FLUSH : RUN;
      FLUSH:   state_n = entry && in_cnt == CW'(NTOT - 1) ? DRAIN : FLUSH;
      default: state_n = m_valid && m_ready && m_last ? IDLE : DRAIN;
    endcase
  end
  // RAM j holds row ir-1-j; the newest window column is the RAM read registers plus pix_d
  for (genvar i = 0; i < K - 1; i++) begin : g_lb
    if (i == 0) begin : g_first
      stencil_line_buffer #(.DEPTH(FRAME_W), .WIDTH(PIX_W), .LAG(1'b0)) u_lb (
        .clk(clk), .rst(rst), .en(entry), .din(pix_in), .dout(rd[i]));
    end else begin : g_next
      stencil_line_buffer #(.DEPTH(FRAME_W), .WIDTH(PIX_W), .LAG(1'b1)) u_lb (
        .clk(clk), .rst(rst), .en(entry), .din(rd[i-1]), .dout(rd[i]));
    end
  end
  always_comb begin
    for (int c = 0; c < K - 1; c++) w[c] = win[c];
    w[K-1][K-1] = pix_d;
    for (int j = 0; j < K - 1; j++) w[K-1][K-2-j] = rd[j];
    acc = '0;
    for (int c = 0; c < K; c++)
      for (int k = 0; k < K; k++)
        acc = acc + AW'($signed({1'b0, w[c][k]})) * AW'(coef[k*K+c]);
    sh = acc >>> shift;
    calc = sh[AW-1] ? '0 : |sh[AW-2:PIX_W] ? '1 : sh[PIX_W-1:0];
    eol = out_col == XW'(FRAME_W - 1);
    brd = out_row < YW'(R) || out_row > YW'(FRAME_H - 1 - R) ||
          out_col < XW'(R) || out_col > XW'(FRAME_W - 1 - R);
    out_pix = !brd || border == BRD_RAW ? calc :
              border == BRD_PASS ? w[R][R] : border == BRD_ZERO ? '0 : '1;
  end
  always_ff @(posedge clk) begin
    if (entry) begin
      for (int c = 0; c < K - 2; c++) win[c] <= win[c+1];
      win[K-2] <= w[K-1];
      pix_d <= pix_in;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      in_cnt <= '0;
      v1 <= 1'b0;
      m_valid <= 1'b0;
      m_data <= '0;
      m_sof <= 1'b0;
      m_last <= 1'b0;
      out_row <= '0;
      out_col <= '0;
      cfg_err <= 1'b0;
      shift <= '0;
      border <= BRD_PASS;
      for (int i = 0; i < KK; i++) coef[i] <= COEF_W'(default_coef(K, i));
    end else begin
      state <= state_n;
      cfg_err <= cfg_we && !cfg_ok;
      if (cfg_we && cfg_ok) begin
        coef[cfg_idx] <= cfg_coef;
        shift <= cfg_shift;
        border <= border_e'(cfg_border);
      end
      if (entry) in_cnt <= in_cnt == CW'(NTOT - 1) ? '0 : in_cnt + CW'(1);
      if (adv) begin
        v1 <= entry && in_cnt >= CW'(OFF);
        m_valid <= v1;
        m_sof <= v1 && out_row == '0 && out_col == '0;
        m_last <= v1 && eol && out_row == YW'(FRAME_H - 1);
        if (v1) begin
          m_data <= out_pix;
          out_col <= eol ? '0 : out_col + XW'(1);
          out_row <= !eol ? out_row : out_row == YW'(FRAME_H - 1) ? '0 : out_row + YW'(1);
        end
      end
    end
  end
endmodule
